// File: rtl/pattern_det_pkg.sv
// Shared types and helpers for the time-shared serial pattern detector.
// Optional feature macro (used by the top level): PAT_PROG_EN.
package pattern_det_pkg;

    localparam int         NCH_DEF     = 4;
    localparam int         PAT_W_DEF   = 4;
    localparam logic [3:0] PATTERN_DEF = 4'b1010;
    localparam int         CNT_W_DEF   = 8;
    localparam int         CH_W        = $clog2(NCH_DEF);

    // History is sized for the longest supported pattern; only the low
    // PAT_W bits are meaningful for a given build.
    localparam int HIST_W_MAX = 16;
    localparam int FILL_W     = 5;

    typedef struct packed {
        logic [HIST_W_MAX-1:0] hist;
        logic [FILL_W-1:0]     fill;
    } ch_state_t;

    // Increment that sticks at lim instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] lim);
        return (val >= lim) ? lim : val + 32'd1;
    endfunction

endpackage

// File: rtl/pattern_det_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or
// after ptr, wrapping around. The pointer itself lives in the parent.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic          en,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    // Scan from ptr upward with wrap and grant the first active request.
    always_comb begin
        logic          found;
        logic [PW-1:0] idx;
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                idx = PW'((int'(ptr) + k) % N);
                if (!found && req[idx]) begin
                    gnt[idx] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pattern_det_scheduler.sv
// One overlapping serial-pattern matcher shared round-robin among NCH bit
// streams, with per-channel history, tagged hit pulses and saturating
// per-channel hit counters.
// Optional feature: define PAT_PROG_EN to add cfg_we/cfg_pat and make the
// active pattern run-time programmable; otherwise the pattern is PATTERN.
module pattern_det_scheduler
    import pattern_det_pkg::*;
#(
    parameter int               NCH     = NCH_DEF,
    parameter int               PAT_W   = PAT_W_DEF,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(PATTERN_DEF),
    parameter int               CNT_W   = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [NCH-1:0]           bit_valid,
    input  logic [NCH-1:0]           bit_data,
    output logic [NCH-1:0]           bit_ready,
    input  logic [NCH-1:0]           ch_clr,
    output logic                     hit_valid,
    output logic [$clog2(NCH)-1:0]   hit_ch,
    input  logic [$clog2(NCH)-1:0]   rd_ch,
    output logic [CNT_W-1:0]         rd_cnt
`ifdef PAT_PROG_EN
    ,
    input  logic                     cfg_we,
    input  logic [PAT_W-1:0]         cfg_pat
`endif
);

    localparam int                    CHB       = $clog2(NCH);
    localparam logic [HIST_W_MAX-1:0] HIST_MASK = HIST_W_MAX'((33'd1 << PAT_W) - 33'd1);
    localparam logic [FILL_W-1:0]     FILL_FULL = FILL_W'(PAT_W);
    localparam logic [31:0]           CNT_MAX   = 32'((33'd1 << CNT_W) - 33'd1);

    ch_state_t        st_q  [NCH];
    ch_state_t        st_d  [NCH];
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];
    logic             hit_valid_q, hit_valid_d;
    logic [CHB-1:0]   hit_ch_q, hit_ch_d;
    logic [CHB-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NCH-1:0]   gnt;
    logic [CHB-1:0]   gnt_idx;
    logic             any_xfer;
    logic [PAT_W-1:0] active_pat;

`ifdef PAT_PROG_EN
    logic [PAT_W-1:0] pat_q, pat_d;
    assign active_pat = pat_q;
`else
    assign active_pat = PATTERN;
`endif

    rr_arbiter #(.N(NCH), .PW(CHB)) u_arb (
        .req (bit_valid),
        .en  (en & ~rst),
        .ptr (rr_ptr_q),
        .gnt (gnt)
    );

    // The grant only ever covers a valid channel, so grant == transfer.
    assign bit_ready = gnt;
    assign any_xfer  = |gnt;
    assign hit_valid = hit_valid_q;
    assign hit_ch    = hit_ch_q;
    assign rd_cnt    = cnt_q[rd_ch];

    // Convert the one-hot grant to a channel index.
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (gnt[i]) gnt_idx = CHB'(i);
        end
    end

    // Next-state: shift the granted bit into its history, detect a hit, bump the counter, then apply clears.
    always_comb begin
        logic [HIST_W_MAX-1:0] new_hist;
        logic [FILL_W-1:0]     new_fill;
        logic                  discard;
        rr_ptr_d    = rr_ptr_q;
        hit_valid_d = 1'b0;
        hit_ch_d    = hit_ch_q;
        new_hist    = '0;
        new_fill    = '0;
        for (int i = 0; i < NCH; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
        end
`ifdef PAT_PROG_EN
        pat_d   = cfg_we ? cfg_pat : pat_q;
        discard = cfg_we;
`else
        discard = 1'b0;
`endif
        if (any_xfer) begin
            rr_ptr_d = (gnt_idx == CHB'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
            new_hist = ((st_q[gnt_idx].hist << 1) | HIST_W_MAX'(bit_data[gnt_idx])) & HIST_MASK;
            new_fill = FILL_W'(sat_inc(32'(st_q[gnt_idx].fill), 32'(PAT_W)));
            discard  = discard | ch_clr[gnt_idx];
            if (!discard) begin
                st_d[gnt_idx].hist = new_hist;
                st_d[gnt_idx].fill = new_fill;
                if (new_hist == HIST_W_MAX'(active_pat) && new_fill == FILL_FULL) begin
                    hit_valid_d    = 1'b1;
                    hit_ch_d       = gnt_idx;
                    cnt_d[gnt_idx] = CNT_W'(sat_inc(32'(cnt_q[gnt_idx]), CNT_MAX));
                end
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (ch_clr[i]) begin
                st_d[i]  = '0;
                cnt_d[i] = '0;
            end
        end
`ifdef PAT_PROG_EN
        if (cfg_we) begin
            for (int i = 0; i < NCH; i++) st_d[i] = '0;
        end
`endif
    end

    // State register with synchronous reset that drops every partial match.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                st_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
            hit_valid_q <= 1'b0;
            hit_ch_q    <= '0;
            rr_ptr_q    <= '0;
`ifdef PAT_PROG_EN
            pat_q       <= PATTERN;
`endif
        end else begin
            for (int i = 0; i < NCH; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            hit_valid_q <= hit_valid_d;
            hit_ch_q    <= hit_ch_d;
            rr_ptr_q    <= rr_ptr_d;
`ifdef PAT_PROG_EN
            pat_q       <= pat_d;
`endif
        end
    end

endmodule

// File: tb/tb_pattern_det_scheduler.sv
// Self-checking bench for pattern_det_scheduler: directed scenarios plus a
// randomized run, all compared against a behavioural model of the scheduler.
// Define PAT_PROG_EN to also exercise the programmable pattern.
module tb_pattern_det_scheduler;
    import pattern_det_pkg::*;

    localparam int NCH     = 4;
    localparam int PAT_W   = 4;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             en        = 1'b0;
    logic [NCH-1:0]   bit_valid = '0;
    logic [NCH-1:0]   bit_data  = '0;
    logic [NCH-1:0]   ch_clr    = '0;
    logic [NCH-1:0]   bit_ready;
    logic             hit_valid;
    logic [CH_W-1:0]  hit_ch;
    logic [CH_W-1:0]  rd_ch     = '0;
    logic [CNT_W-1:0] rd_cnt;
    logic             cfg_we    = 1'b0;
    logic [PAT_W-1:0] cfg_pat   = '0;

    // Behavioural model: histories as integers of the last PAT_W bits.
    int m_hist [NCH];
    int m_fill [NCH];
    int m_cnt  [NCH];
    int m_ptr;
    int m_pat;
    int m_hit_ch;
    bit m_hit_valid;

    int             vectors     = 0;
    int             miscompares = 0;
    int             rd_sel      = -1;
    logic [NCH-1:0] last_ready;
    int             rr_exp [5]  = '{1, 2, 4, 8, 1};

    pattern_det_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .bit_valid (bit_valid),
        .bit_data  (bit_data),
        .bit_ready (bit_ready),
        .ch_clr    (ch_clr),
        .hit_valid (hit_valid),
        .hit_ch    (hit_ch),
        .rd_ch     (rd_ch),
        .rd_cnt    (rd_cnt)
`ifdef PAT_PROG_EN
        ,
        .cfg_we    (cfg_we),
        .cfg_pat   (cfg_pat)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NCH; i++) begin
            m_hist[i] = 0;
            m_fill[i] = 0;
            m_cnt[i]  = 0;
        end
        m_ptr       = 0;
        m_pat       = 'b1010;
        m_hit_ch    = 0;
        m_hit_valid = 1'b0;
    endtask

    // Drive one cycle of inputs, check outputs against the model, then advance the model across the edge.
    task automatic applyStimulus(input logic [NCH-1:0] v, input logic [NCH-1:0] d,
                                 input logic [NCH-1:0] c, input logic e, input logic r,
                                 input logic cw, input logic [PAT_W-1:0] cp);
        int g;
        int exp_gnt;
        int rs;
`ifndef PAT_PROG_EN
        cw = 1'b0;
`endif
        @(negedge clk);
        rs        = (rd_sel < 0) ? int'($urandom_range(0, NCH - 1)) : rd_sel;
        bit_valid = v;
        bit_data  = d;
        ch_clr    = c;
        en        = e;
        rst       = r;
        cfg_we    = cw;
        cfg_pat   = cp;
        rd_ch     = CH_W'(rs);
        #1;
        g = -1;
        if (!r && e) begin
            for (int k = 0; k < NCH; k++) begin
                int idx;
                idx = (m_ptr + k) % NCH;
                if (g < 0 && v[idx]) g = idx;
            end
        end
        exp_gnt    = (g < 0) ? 0 : (1 << g);
        last_ready = bit_ready;
        checkOutput("bit_ready", 32'(bit_ready), 32'(exp_gnt));
        checkOutput("hit_valid", 32'(hit_valid), 32'(m_hit_valid));
        checkOutput("hit_ch",    32'(hit_ch),    32'(m_hit_ch));
        checkOutput("rd_cnt",    32'(rd_cnt),    32'(m_cnt[rs]));
        if (r) begin
            modelReset();
        end else begin
            m_hit_valid = 1'b0;
            if (g >= 0) begin
                m_ptr = (g + 1) % NCH;
                if (!c[g] && !cw) begin
                    m_hist[g] = ((m_hist[g] * 2) + int'(d[g])) % (1 << PAT_W);
                    if (m_fill[g] < PAT_W) m_fill[g]++;
                    if (m_fill[g] == PAT_W && m_hist[g] == m_pat) begin
                        m_hit_valid = 1'b1;
                        m_hit_ch    = g;
                        if (m_cnt[g] < CNT_MAX) m_cnt[g]++;
                    end
                end
            end
            for (int i = 0; i < NCH; i++) begin
                if (c[i]) begin
                    m_hist[i] = 0;
                    m_fill[i] = 0;
                    m_cnt[i]  = 0;
                end
            end
            if (cw) begin
                m_pat = int'(cp);
                for (int i = 0; i < NCH; i++) begin
                    m_hist[i] = 0;
                    m_fill[i] = 0;
                end
            end
        end
    endtask

    task automatic sendBit(input int ch, input logic b);
        applyStimulus(NCH'(1 << ch), NCH'(int'(b) << ch), '0, 1'b1, 1'b0, 1'b0, '0);
    endtask

    task automatic idleCycle();
        applyStimulus('0, '0, '0, 1'b1, 1'b0, 1'b0, '0);
    endtask

    task automatic resetCycle();
        applyStimulus('0, '0, '0, 1'b1, 1'b1, 1'b0, '0);
    endtask

    initial begin
        logic [7:0] seq;
        modelReset();
        repeat (2) @(posedge clk);
        resetCycle();
        resetCycle();

        // Single stream on ch0: hits after the 4th and 6th bits.
        rd_sel = 0;
        seq    = 8'b0010_1010;
        for (int i = 5; i >= 0; i--) sendBit(0, seq[i]);
        idleCycle();
        checkOutput("ch0_two_hits", 32'(rd_cnt), 32'd2);

        // All channels requesting from rr_ptr=0: grants rotate 0,1,2,3,0.
        resetCycle();
        rd_sel = -1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus('1, NCH'($urandom), '0, 1'b1, 1'b0, 1'b0, '0);
            checkOutput("rr_grant", 32'(last_ready), 32'(rr_exp[i]));
        end

        // ch2 sends 1,0,1 then a 0 coinciding with its clear.
        resetCycle();
        rd_sel = 2;
        sendBit(2, 1'b1);
        sendBit(2, 1'b0);
        sendBit(2, 1'b1);
        applyStimulus(4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b0, '0);
        idleCycle();
        checkOutput("clr_nohit", 32'(hit_valid), 32'd0);
        checkOutput("clr_cnt",   32'(rd_cnt),    32'd0);
        sendBit(2, 1'b0);
        sendBit(2, 1'b1);
        sendBit(2, 1'b0);
        idleCycle();

        // Saturate the ch1 counter, then one more hit.
        resetCycle();
        rd_sel = 1;
        for (int i = 0; i < 260; i++) begin
            sendBit(1, 1'b1);
            sendBit(1, 1'b0);
        end
        idleCycle();
        checkOutput("sat_pulse", 32'(hit_valid), 32'd1);
        checkOutput("cnt1_sat",  32'(rd_cnt),    32'd255);

        // Reset in the middle of a partial match on ch3.
        rd_sel = 3;
        sendBit(3, 1'b1);
        sendBit(3, 1'b0);
        sendBit(3, 1'b1);
        resetCycle();
        sendBit(3, 1'b0);
        idleCycle();
        checkOutput("rst_nohit", 32'(hit_valid), 32'd0);
        checkOutput("rst_cnt3",  32'(rd_cnt),    32'd0);

`ifdef PAT_PROG_EN
        // Program 1100: 1,1,0,0 hits once, 1,0,1,0 does not.
        resetCycle();
        rd_sel = 0;
        applyStimulus('0, '0, '0, 1'b1, 1'b0, 1'b1, 4'b1100);
        sendBit(0, 1'b1);
        sendBit(0, 1'b1);
        sendBit(0, 1'b0);
        sendBit(0, 1'b0);
        idleCycle();
        checkOutput("prog_hit", 32'(hit_valid), 32'd1);
        sendBit(0, 1'b1);
        sendBit(0, 1'b0);
        sendBit(0, 1'b1);
        sendBit(0, 1'b0);
        idleCycle();
        checkOutput("prog_cnt", 32'(rd_cnt), 32'd1);
`endif

        // Randomized traffic with occasional clears, enable drops, resets and reprogramming.
        rd_sel = -1;
        for (int i = 0; i < 3000; i++) begin
            logic [NCH-1:0] c;
            c = ($urandom_range(0, 31) == 0) ? NCH'(1 << $urandom_range(0, NCH - 1)) : '0;
            applyStimulus(NCH'($urandom), NCH'($urandom), c,
                          ($urandom_range(0, 9) != 0), ($urandom_range(0, 199) == 0),
                          ($urandom_range(0, 99) == 0), PAT_W'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
